// File: rtl/audio_pkg.sv
// Shared audio-path constants and the stereo sample word type.
package audio_pkg;

  localparam int SAMPLE_BITS = 16;
  localparam int CLK_DIV     = 8;

  typedef logic [2*SAMPLE_BITS-1:0] stereo_sample_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit-clock divider: BCLK register plus a one-cycle strobe
// coincident with each BCLK falling edge (the slot boundary).
module i2s_clk_gen #(
  parameter int CLK_DIV = audio_pkg::CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic fall_stb
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap     = (div_cnt == DIV_LAST);
  assign fall_stb = wrap & bclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + DW'(1);
      if (wrap) bclk <= ~bclk;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S transmitter; define I2S_LEFT_JUSTIFIED_EN for the
// left-justified format instead of standard one-BCLK-delayed I2S.
module i2s_tx #(
  parameter int SAMPLE_BITS = audio_pkg::SAMPLE_BITS,
  parameter int CLK_DIV     = audio_pkg::CLK_DIV
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [2*SAMPLE_BITS-1:0] sample_i,
  output logic                     sample_req_o,
  output logic                     i2s_bclk_o,
  output logic                     i2s_lrclk_o,
  output logic                     i2s_sdata_o
);

  localparam int FB = 2 * SAMPLE_BITS;
  localparam int SW = (FB > 1) ? $clog2(FB) : 1;
  localparam logic [SW-1:0] LAST  = SW'(FB - 1);
  localparam logic [SW-1:0] RIGHT = SW'(SAMPLE_BITS);

  logic          fall_stb;
  logic          bclk;
  logic [SW-1:0] slot;
  logic [SW-1:0] ns;
  logic [FB-1:0] sh;
  logic          tx_bit;
  logic          lrclk;
  logic          sdata;
  logic          req;

  i2s_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk      (clk_i),
    .rst      (rst_i),
    .bclk     (bclk),
    .fall_stb (fall_stb)
  );

  assign ns = (slot == LAST) ? '0 : slot + SW'(1);

`ifdef I2S_LEFT_JUSTIFIED_EN
  // Slot 0 carries the MSB of the word being loaded this edge
  always_comb begin
    tx_bit = 1'b0;
    if (ns == '0) tx_bit = sample_i[FB-1];
    else          tx_bit = sh[LAST - ns];
  end
`else
  logic last_bit;

  always_comb begin
    tx_bit = 1'b0;
    if (ns == '0) tx_bit = last_bit;
    else          tx_bit = sh[SW'(FB) - ns];
  end

  // Saved ahead of the reload so slot 0 can still send the old LSB
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_bit <= 1'b0;
    end else if (fall_stb && ns == LAST) begin
      last_bit <= sh[0];
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot  <= '0;
      sh    <= '0;
      lrclk <= 1'b0;
      sdata <= 1'b0;
      req   <= 1'b0;
    end else begin
      req <= fall_stb && (ns == LAST);
      if (fall_stb) begin
        slot  <= ns;
        lrclk <= (ns >= RIGHT);
        sdata <= tx_bit;
        if (ns == '0) sh <= sample_i;
      end
    end
  end

  assign sample_req_o = req;
  assign i2s_bclk_o   = bclk;
  assign i2s_lrclk_o  = lrclk;
  assign i2s_sdata_o  = sdata;

endmodule
